byte_to_bcd_scan: RTL
=====================

# byte_to_bcd_scan

Upstream feeder for the seven-segment decoder. Takes each byte from the UART receiver and converts it to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine, holding the last result. It then time-multiplexes the held digits onto a single 4-bit BCD bus with a matching active-low digit enable, so one decoder instance can drive a 3-digit display.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal range ≥ 2.
- BLANK_LZ, 1: 1 = blank leading zeros on hundreds/tens; 0 = always show all digits.

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received byte, unsigned 0–255.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- busy  out  1  high while a conversion is in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse; new digits visible in the same cycle.
- dropped  out  1  one-cycle pulse; a byte was rejected because busy.
- bcd_hund, bcd_tens, bcd_ones  out  4 each  held result digits.
- scan_bcd  out  4  digit currently presented to the 7-segment decoder.
- digit_an  out  3  active-low one-hot digit enable: [0]=ones, [1]=tens, [2]=hundreds.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On rx_valid, load the 20-bit shift register with {12'b0, rx_data}.
  - Clear the 3-bit iteration counter and go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to each BCD nibble (bits [19:16], [15:12], [11:8]) whose value is ≥ 5.
  - Then shift the whole register left by 1.
  - After the 8th iteration, go to DONE.
- DONE:
  - Copy the nibbles to bcd_hund/tens/ones, pulse done, return to IDLE.
  - Held digits change only in DONE.
- Arithmetic: the add-3 result always fits in a nibble. The 20-bit register has no overflow for inputs 0–255, and the hundreds digit never exceeds 2.
- rx_valid while busy (SHIFT or DONE):
  - The byte is discarded and dropped pulses on the next cycle.
  - The in-flight conversion is unaffected.
- Scan engine, free-running and independent of the FSM:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances ones → tens → hundreds → ones.
- scan_bcd is the held digit for the current index. digit_an is 3'b110 (ones), 3'b101 (tens) or 3'b011 (hundreds).
- Blanking with BLANK_LZ=1:
  - The hundreds digit presents 4'hF when bcd_hund==0.
  - The tens digit presents 4'hF when bcd_hund==0 and bcd_tens==0.
  - Ones is never blanked.
  - 4'hF is outside 0–9, so the decoder's default blanks the segments.
- Blanking affects scan_bcd only; bcd_* outputs always carry true values.

## Timing
- Reset values:
  - busy=0, done=0, dropped=0.
  - bcd_hund=bcd_tens=bcd_ones=0.
  - Scan index=ones, prescaler=0, digit_an=3'b110.
  - scan_bcd=0 (ones digit, never blanked).
- Latency:
  - rx_valid sampled at edge E0.
  - busy high in cycles E0+1 through E0+9.
  - done high and new digits visible in cycle E0+9.
  - busy low from E0+10; a new rx_valid is accepted from cycle E0+10.
- Maximum throughput: one byte per 10 cycles.
- Reset mid-conversion:
  - All registers return to reset values immediately (asynchronous).
  - No done is issued and the partial result is lost.
- Asserting rx_valid in the DONE cycle counts as busy and is dropped.
- Scan:
  - digit_an and scan_bcd change only on prescaler wrap, so each digit is held exactly SCAN_DIV cycles.
  - A digit update mid-slot appears on scan_bcd in the same cycle as done.

## Test plan
- Reset: rst_n low, then high → bcd_* = 0, digit_an=3'b110, scan_bcd=0, busy/done/dropped=0.
- rx_data=255 with rx_valid at E0 → done exactly at E0+9; hund/tens/ones = 2/5/5; busy high E0+1..E0+9 only.
- Back-to-back values 0, 9, 10, 99, 100, 199 at 10-cycle spacing → 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 1/9/9.
- rx_data=200, then a second rx_valid with 7 at E0+4 → dropped pulses at E0+5; digits become 2/0/0; no second done.
- SCAN_DIV=4, BLANK_LZ=1, value 7 → digit_an cycles 110, 101, 011, each held 4 cycles; scan_bcd = 7, F, F. With value 42: 2, 4, F.
- rst_n low at E0+4 during conversion of 123 → busy=0 immediately, no done, digits 0. After release, 45 converts to 0/4/5 with done at +9.

Source files
------------

// File: rtl/byte_to_bcd_scan_if.sv
// Bus between the UART receiver side and the BCD conversion/scan block.
// The master drives received bytes; the slave returns status, held digits and scan outputs.
interface byte_to_bcd_scan_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       dropped;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [3:0] scan_bcd;
  logic [2:0] digit_an;

  modport master (
    output rx_data, rx_valid,
    input  busy, done, dropped, bcd_hund, bcd_tens, bcd_ones, scan_bcd, digit_an
  );

  modport slave (
    input  rx_data, rx_valid,
    output busy, done, dropped, bcd_hund, bcd_tens, bcd_ones, scan_bcd, digit_an
  );
endinterface

// File: rtl/byte_to_bcd_scan.sv
// Sequential double-dabble byte-to-BCD converter with a held result, followed by
// a free-running 3-digit scan multiplexer with optional leading-zero blanking.
module byte_to_bcd_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  byte_to_bcd_scan_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q;
  logic [19:0]   shift_q;
  logic [19:0]   shift_d;
  logic [19:0]   adj;
  logic [2:0]    iter_q;
  logic [3:0]    hund_q, tens_q, ones_q;
  logic          done_q, dropped_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  // One double-dabble step: correct every BCD nibble that would overflow, then shift.
  always_comb begin
    adj = shift_q;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    shift_d = {adj[18:0], 1'b0};
  end

  // Digits are captured on the SHIFT->DONE edge so they are visible alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      iter_q    <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dropped_q <= bus.rx_valid && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            shift_q <= {12'b0, bus.rx_data};
            iter_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          iter_q  <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            hund_q  <= shift_d[19:16];
            tens_q  <= shift_d[15:12];
            ones_q  <= shift_d[11:8];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Selection is combinational from the held digits so a fresh result shows mid-slot.
  always_comb begin
    bus.digit_an = 3'b110;
    bus.scan_bcd = ones_q;
    case (idx_q)
      2'd1: begin
        bus.digit_an = 3'b101;
        bus.scan_bcd = (BLANK_LZ && hund_q == 4'd0 && tens_q == 4'd0) ? 4'hF : tens_q;
      end
      2'd2: begin
        bus.digit_an = 3'b011;
        bus.scan_bcd = (BLANK_LZ && hund_q == 4'd0) ? 4'hF : hund_q;
      end
      default: begin
        bus.digit_an = 3'b110;
        bus.scan_bcd = ones_q;
      end
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.dropped  = dropped_q;
  assign bus.bcd_hund = hund_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;

endmodule
